// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: command/response front end for alu_32.
// Takes one {A, B, op} command, holds the ALU operands for a fixed per-op
// wait (with a one-cycle ALU reset pulse first for Mod), then captures
// alu_res and offers it on a valid/ready response channel.
module alu_cmd_driver #(
    parameter int unsigned COMB_WAIT = 1,
    parameter int unsigned MOD_WAIT  = 50,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_reset,
    input  logic [31:0] alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic [2:0]  rsp_op,
    output logic        busy
);

    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic last_wait;

    assign accept    = cmd_valid && (state == IDLE);
    assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // Combinational so the ALU is also cleared for the whole system reset.
    assign alu_reset = reset || (state == CLR);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_op == OP_MOD) ? CLR : WAIT;
                end
            end
            CLR:  state_nxt = WAIT;
            WAIT: begin
                if (last_wait) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand hold, wait counter and response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_op    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        if (cmd_op != OP_MOD) begin
                            cnt <= CNT_W'(COMB_WAIT);
                        end
                    end
                end
                CLR: begin
                    cnt <= CNT_W'(MOD_WAIT);
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_wait) begin
                        rsp_res   <= alu_res;
                        rsp_op    <= alu_op;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural alu_32 stand-in.
// The Mod path of the stand-in is iterative (repeated subtraction after
// its reset) so the result only becomes valid some cycles after the pulse.
module tb_alu_cmd_driver;

    localparam int unsigned COMB_WAIT = 1;
    localparam int unsigned MOD_WAIT  = 50;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_reset;
    logic [31:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic [2:0]  rsp_op;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_cmd_driver #(
        .COMB_WAIT(COMB_WAIT),
        .MOD_WAIT (MOD_WAIT),
        .CNT_W    (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_op   (cmd_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_reset(alu_reset),
        .alu_res  (alu_res),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_res  (rsp_res),
        .rsp_op   (rsp_op),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Behavioural alu_32: iterative remainder unit, cleared by alu_reset.
    logic [31:0] mod_reg;
    always_ff @(posedge clock) begin
        if (alu_reset) begin
            mod_reg <= alu_a;
        end else if (alu_b != 0 && mod_reg >= alu_b) begin
            mod_reg <= mod_reg - alu_b;
        end
    end

    // Behavioural alu_32: combinational ops.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b010: alu_res = alu_a ^ alu_b;
            3'b011: alu_res = ~(alu_a | alu_b);
            3'b100: alu_res = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            3'b101: alu_res = alu_a + alu_b;
            3'b110: alu_res = alu_a - alu_b;
            default: alu_res = mod_reg;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one command (called just after a clock edge, DUT idle) and
    // check latency, result, echoed op, ALU reset pulse and cmd_ready.
    task automatic do_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_res,
                          input logic [31:0] mask);
        int n;
        int rc;
        int rdy;
        int exp_lat;
        exp_lat = (op == 3'b111) ? int'(1 + MOD_WAIT) : int'(COMB_WAIT);
        check({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        rc  = alu_reset ? 1 : 0;
        rdy = cmd_ready ? 1 : 0;
        n   = 0;
        while (n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (rsp_valid) break;
            if (alu_reset) rc++;
            if (cmd_ready) rdy++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".res"}, rsp_res & mask, exp_res);
        check({tag, ".op"}, 32'(rsp_op), 32'(op));
        check({tag, ".rst_pulse"}, 32'(rc), (op == 3'b111) ? 32'd1 : 32'd0);
        check({tag, ".ready_low"}, 32'(rdy), 32'd0);
        @(posedge clock);
        #1;
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    logic [31:0] q_a   [8] = '{32'hFF00FF00, 32'h12340000, 32'hAAAAAAAA, 32'h0000FFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd10,       32'd100};
    logic [31:0] q_b   [8] = '{32'h0FF00FF0, 32'h00005678, 32'hFFFFFFFF, 32'h00FF0000,
                               32'd1,        32'd1,        32'd20,       32'd7};
    logic [2:0]  q_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] q_exp [8] = '{32'h0F000F00, 32'h12345678, 32'h55555555, 32'hFF000000,
                               32'h00000001, 32'h00000000, 32'hFFFFFFF6, 32'h00000002};

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.alu_reset", 32'(alu_reset), 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.alu_a", alu_a, 32'd0);
        check("rst.alu_b", alu_b, 32'd0);
        check("rst.alu_op", 32'(alu_op), 32'd0);
        check("rst.rsp_res", rsp_res, 32'd0);
        check("rst.rsp_op", 32'(rsp_op), 32'd0);
        check("rst.alu_reset_off", 32'(alu_reset), 32'd0);

        // Op sweep.
        do_cmd("and", 32'h00000000, 32'hFFFFFFFF, 3'b000, 32'h00000000, '1);
        do_cmd("or",  32'h00000000, 32'hFFFFFFFF, 3'b001, 32'hFFFFFFFF, '1);
        do_cmd("xor", 32'h00000000, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF, '1);
        do_cmd("nor", 32'h00000000, 32'hFFFFFFFF, 3'b011, 32'h00000000, '1);
        do_cmd("slt", 32'd1, 32'd3, 3'b100, 32'd1, 32'd1);
        do_cmd("add", 32'd3, 32'd3, 3'b101, 32'd6, '1);
        do_cmd("sub", 32'd5, 32'd3, 3'b110, 32'd2, '1);
        do_cmd("mod", 32'd13, 32'd5, 3'b111, 32'd3, '1);
        check("hold.alu_a", alu_a, 32'd13);
        check("hold.alu_op", 32'(alu_op), 32'd7);

        // Backpressure.
        begin
            int n;
            int unstable;
            cmd_a = 32'd7; cmd_b = 32'd8; cmd_op = 3'b101;
            cmd_valid = 1'b1;
            rsp_ready = 1'b0;
            @(posedge clock);
            #1;
            cmd_a = 32'h000000F0; cmd_b = 32'h000000FF; cmd_op = 3'b010;
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("bp.latency", 32'(n), 32'(COMB_WAIT));
            unstable = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clock);
                #1;
                if (rsp_valid !== 1'b1 || rsp_res !== 32'd15 || rsp_op !== 3'b101 ||
                    cmd_ready !== 1'b0 || alu_a !== 32'd7)
                    unstable++;
            end
            check("bp.stable", 32'(unstable), 32'd0);
            rsp_ready = 1'b1;
            @(posedge clock);
            #1;
            check("bp.valid_drop", 32'(rsp_valid), 32'd0);
            check("bp.ready_up", 32'(cmd_ready), 32'd1);
            @(posedge clock);
            #1;
            cmd_valid = 1'b0;
            check("bp.second_busy", 32'(busy), 32'd1);
            check("bp.second_a", alu_a, 32'h000000F0);
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(posedge clock);
                #1;
                n++;
            end
            check("bp.second_res", rsp_res, 32'h0000000F);
            @(posedge clock);
            #1;
        end

        // Reset 20 cycles into the Mod wait.
        cmd_a = 32'd13; cmd_b = 32'd5; cmd_op = 3'b111;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (21) @(posedge clock);
        #1;
        check("mrst.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mrst.alu_reset", 32'(alu_reset), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mrst.idle", 32'(busy), 32'd0);
        check("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst.alu_a", alu_a, 32'd0);
        do_cmd("mrst.add", 32'd2, 32'd2, 3'b101, 32'd4, '1);

        // Back-to-back queue.
        begin
            int idle_cnt;
            int got;
            idle_cnt = 0;
            got = 0;
            rsp_ready = 1'b1;
            fork
                begin
                    int i;
                    int guard;
                    i = 0;
                    guard = 0;
                    cmd_a = q_a[0]; cmd_b = q_b[0]; cmd_op = q_op[0];
                    cmd_valid = 1'b1;
                    while (i < 8 && guard < 2000) begin
                        @(negedge clock);
                        guard++;
                        if (cmd_ready) begin
                            @(posedge clock);
                            #1;
                            i++;
                            if (i < 8) begin
                                cmd_a = q_a[i]; cmd_b = q_b[i]; cmd_op = q_op[i];
                            end
                        end
                    end
                    cmd_valid = 1'b0;
                end
                begin
                    int guard;
                    guard = 0;
                    while (got < 8 && guard < 2000) begin
                        @(negedge clock);
                        guard++;
                        if (!busy) begin
                            idle_cnt++;
                            if (!cmd_valid) idle_cnt += 100;
                        end
                        if (rsp_valid) begin
                            check($sformatf("b2b.res%0d", got), rsp_res, q_exp[got]);
                            check($sformatf("b2b.op%0d", got), 32'(rsp_op), 32'(q_op[got]));
                            got++;
                        end
                    end
                end
            join
            check("b2b.count", 32'(got), 32'd8);
            check("b2b.idle_cycles", 32'(idle_cnt), 32'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Hardware initiator that sits in front of alu_32 and replaces hand-sequenced stimulus with a command/response interface.
- Accepts one {A, B, op} command over valid/ready and drives alu_32 operands and op.
- For op 3'b111 (Mod) it first pulses the ALU reset, then waits for the iterative unit to settle.
- Samples alu_32 res after a fixed per-op wait and returns it over a valid/ready response channel.

Parameters:
- COMB_WAIT, 1, cycles operands are held before sampling res for ops 000–110 (min 1).
- MOD_WAIT, 50, cycles operands are held after the ALU reset pulse before sampling res for op 111 (min 1).
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > max(COMB_WAIT, MOD_WAIT).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- cmd_op  input  3  ALU op: 000 And, 001 Or, 010 Xor, 011 Nor, 100 Slt, 101 Add, 110 Sub, 111 Mod.
- alu_a  output  32  to alu_32 A.
- alu_b  output  32  to alu_32 B.
- alu_op  output  3  to alu_32 Alu_Op.
- alu_reset  output  1  to alu_32 reset.
- alu_res  input  32  from alu_32 res.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_res  output  32  captured result.
- rsp_op  output  3  op that produced rsp_res.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; alu_a, alu_b, rsp_res = 0; alu_op, rsp_op = 000; rsp_valid = 0; counter = 0.
- alu_reset = reset OR (state == CLR). It is combinational so the ALU is cleared during system reset.
- States: IDLE, CLR, WAIT, RESP.
- cmd_ready = 1 only in IDLE. There is no acceptance in RESP, even if rsp_ready is high in the same cycle.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready; call it edge k.
  - On edge k, alu_a/alu_b/alu_op load cmd_a/cmd_b/cmd_op.
- IDLE -> WAIT on accept when op != 111; counter loads COMB_WAIT.
- IDLE -> CLR on accept when op == 111.
- CLR lasts exactly 1 cycle with alu_reset = 1 and operands already driven. It then goes to WAIT with counter = MOD_WAIT.
- WAIT decrements the counter each cycle. On the edge where counter == 1:
  - rsp_res <= alu_res and rsp_op <= alu_op;
  - rsp_valid <= 1;
  - go to RESP.
- Latency from accept edge k to rsp_valid first high:
  - non-mod: k + COMB_WAIT;
  - mod: k + 1 + MOD_WAIT.
- RESP holds rsp_valid, rsp_res and rsp_op stable until rsp_valid && rsp_ready. On that edge rsp_valid <= 0 and the state returns to IDLE; cmd_ready rises the following cycle.
- alu_a, alu_b and alu_op stay held after completion until the next accept. The ALU is never presented with changing operands mid-operation.
- cmd_* changes while not accepted are ignored.
- Widths:
  - rsp_res carries alu_res unmodified (32 bits).
  - For Slt only bit 0 is meaningful; the block does not mask.
  - No overflow or carry reporting.
- Reset mid-operation (any state):
  - next cycle is IDLE with all reset values;
  - any pending response is dropped;
  - alu_reset is high for the duration of reset.
- rsp_ready high while not in RESP has no effect.

Test Plan:
- Directed op sweep, each with rsp_ready = 1, against a real alu_32; each rsp_valid must appear exactly COMB_WAIT cycles after accept:
  - A=0x00000000, B=0xFFFFFFFF, op 000 -> rsp_res 0x00000000.
  - Same operands, op 001 -> 0xFFFFFFFF; op 010 -> 0xFFFFFFFF; op 011 -> 0x00000000.
- Slt/Add/Sub:
  - A=1, B=3, op 100 -> rsp_res[0] = 1.
  - A=3, B=3, op 101 -> 6.
  - A=5, B=3, op 110 -> 2.
  - rsp_op must echo the op in each case.
- Mod: A=13, B=5, op 111 -> alu_reset high exactly 1 cycle (edge k+1), rsp_valid at k+1+MOD_WAIT, rsp_res = 3; cmd_ready low throughout.
- Backpressure:
  - Hold rsp_ready = 0 for 10 cycles after rsp_valid -> rsp_res/rsp_op/rsp_valid stable, cmd_ready = 0, a second cmd_valid is not accepted.
  - Raise rsp_ready -> rsp_valid drops next edge and the second command is accepted one cycle later.
- Reset mid-Mod: assert reset for 1 cycle at 20 cycles into WAIT -> state IDLE, rsp_valid = 0, alu_reset = 1 during reset. A fresh Add 2+2 then returns 4 with normal latency.
- Back-to-back: 8 queued commands with cmd_valid continuously high, rsp_ready = 1 -> exactly 8 responses in order, no duplicates or drops, busy low only between responses and the next accept.
